scan_decoder: RTL and testbench

//   Parametrised, registered binary-to-one-hot decoder with a built-in scan sequencer.

---
 rtl/scan_decoder_if.sv | 26 ++
 rtl/scan_decoder.sv | 80 ++++++++
 tb/tb_scan_decoder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/scan_decoder_if.sv
// Bus bundle for scan_decoder: control strobes and index inputs, and the registered decode results.
interface scan_decoder_if #(
   parameter int unsigned SEL_W = 3
);
   localparam int unsigned OUT_W = 2**SEL_W;

   logic             enable;
   logic             mode;
   logic             load;
   logic [SEL_W-1:0] binary_in;
   logic             tick;
   logic [SEL_W-1:0] scan_last;
   logic [OUT_W-1:0] decoder_out;
   logic [SEL_W-1:0] index_out;
   logic             wrap;

   modport master (
      output enable, mode, load, binary_in, tick, scan_last,
      input  decoder_out, index_out, wrap
   );

   modport slave (
      input  enable, mode, load, binary_in, tick, scan_last,
      output decoder_out, index_out, wrap
   );
endinterface

// File: rtl/scan_decoder.sv
// Registered binary-to-one-hot decoder with a round-robin scan sequencer.
// DIRECT decodes a loaded index; SCAN advances the index on each tick strobe.
module scan_decoder #(
   parameter int unsigned SEL_W      = 3,
   parameter bit          ACTIVE_LOW = 1'b0
) (
   input  logic           clk,
   input  logic           rst,
   scan_decoder_if.slave  bus
);
   localparam int unsigned      OUT_W    = 2**SEL_W;
   localparam logic [OUT_W-1:0] INACTIVE = {OUT_W{ACTIVE_LOW}};

   typedef enum logic [1:0] {OFF, DIRECT, SCAN} state_e;

   state_e           state_q, state_d;
   logic [SEL_W-1:0] index_q, index_d;
   logic [OUT_W-1:0] decoder_out_q, decoder_out_d;
   logic             wrap_q, wrap_d;
   logic [OUT_W-1:0] one_hot;

   // State and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= OFF;
         index_q       <= '0;
         decoder_out_q <= INACTIVE;
         wrap_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         index_q       <= index_d;
         decoder_out_q <= decoder_out_d;
         wrap_q        <= wrap_d;
      end
   end

   // Next state, next index and decode; actions follow the state being entered this edge
   always_comb begin
      state_d       = state_q;
      index_d       = index_q;
      wrap_d        = 1'b0;
      decoder_out_d = decoder_out_q;
      one_hot       = '0;

      if (!bus.enable)    state_d = OFF;
      else if (!bus.mode) state_d = DIRECT;
      else                state_d = SCAN;

      case (state_d)
         DIRECT: begin
            if (bus.load) index_d = bus.binary_in;
         end
         SCAN: begin
            if (bus.load) begin
               index_d = bus.binary_in;
            end else if (bus.tick) begin
               // >= so a scan_last lowered below the index wraps instead of running on
               if (index_q >= bus.scan_last) begin
                  index_d = '0;
                  wrap_d  = 1'b1;
               end else begin
                  index_d = index_q + SEL_W'(1);
               end
            end
         end
         default: ;
      endcase

      one_hot = OUT_W'(1) << index_d;

      // Decode only changes when state or index does, so hold otherwise
      if ((state_d != state_q) || (index_d != index_q)) begin
         decoder_out_d = (state_d == OFF) ? INACTIVE : (one_hot ^ INACTIVE);
      end
   end

   assign bus.decoder_out = decoder_out_q;
   assign bus.index_out   = index_q;
   assign bus.wrap        = wrap_q;
endmodule

// File: tb/tb_scan_decoder.sv
// Directed bench for scan_decoder: 3-bit active-high, 3-bit active-low mirror and 4-bit instances.
module tb_scan_decoder;
   logic clk;
   logic rst;
   int   vectors = 0;
   int   errors  = 0;

   scan_decoder_if #(.SEL_W(3)) if8 ();
   scan_decoder_if #(.SEL_W(3)) if_al ();
   scan_decoder_if #(.SEL_W(4)) if16 ();

   scan_decoder #(.SEL_W(3), .ACTIVE_LOW(1'b0)) dut8   (.clk(clk), .rst(rst), .bus(if8));
   scan_decoder #(.SEL_W(3), .ACTIVE_LOW(1'b1)) dut_al (.clk(clk), .rst(rst), .bus(if_al));
   scan_decoder #(.SEL_W(4), .ACTIVE_LOW(1'b0)) dut16  (.clk(clk), .rst(rst), .bus(if16));

   // Active-low instance mirrors the stimulus of the 3-bit active-high one
   assign if_al.enable    = if8.enable;
   assign if_al.mode      = if8.mode;
   assign if_al.load      = if8.load;
   assign if_al.binary_in = if8.binary_in;
   assign if_al.tick      = if8.tick;
   assign if_al.scan_last = if8.scan_last;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic edge1();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      if8.enable = 1'b0; if8.mode = 1'b0; if8.load = 1'b0; if8.binary_in = '0;
      if8.tick = 1'b0; if8.scan_last = 3'd7;
      if16.enable = 1'b0; if16.mode = 1'b0; if16.load = 1'b0; if16.binary_in = '0;
      if16.tick = 1'b0; if16.scan_last = 4'd15;
      edge1();
      vectors++;
      if (if8.decoder_out !== 8'h00 || if8.index_out !== 3'd0 || if8.wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset8 dec=%h idx=%0d wrap=%b expected 00/0/0", if8.decoder_out, if8.index_out, if8.wrap);
      end
      vectors++;
      if (if_al.decoder_out !== 8'hFF || if_al.index_out !== 3'd0 || if_al.wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset_al dec=%h idx=%0d wrap=%b expected ff/0/0", if_al.decoder_out, if_al.index_out, if_al.wrap);
      end
      vectors++;
      if (if16.decoder_out !== 16'h0000 || if16.index_out !== 4'd0 || if16.wrap !== 1'b0) begin
         errors++;
         $display("FAIL reset16 dec=%h idx=%0d wrap=%b expected 0000/0/0", if16.decoder_out, if16.index_out, if16.wrap);
      end
      @(negedge clk);
      rst = 1'b0;
      edge1();
      vectors++;
      if (if8.decoder_out !== 8'h00 || if_al.decoder_out !== 8'hFF || if8.index_out !== 3'd0) begin
         errors++;
         $display("FAIL reset_release dec=%h al=%h idx=%0d expected 00/ff/0", if8.decoder_out, if_al.decoder_out, if8.index_out);
      end
   endtask

   task automatic test_direct();
      if8.enable = 1'b1; if8.mode = 1'b0; if8.load = 1'b1; if8.binary_in = 3'd5;
      edge1();
      if8.load = 1'b0;
      vectors++;
      if (if8.decoder_out !== 8'h20 || if8.index_out !== 3'd5 || if8.wrap !== 1'b0 || if_al.decoder_out !== 8'hDF) begin
         errors++;
         $display("FAIL direct_load dec=%h idx=%0d wrap=%b al=%h expected 20/5/0/df",
                  if8.decoder_out, if8.index_out, if8.wrap, if_al.decoder_out);
      end
      if8.tick = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge1();
         vectors++;
         if (if8.decoder_out !== 8'h20 || if8.index_out !== 3'd5 || if8.wrap !== 1'b0) begin
            errors++;
            $display("FAIL direct_tick_ignored[%0d] dec=%h idx=%0d wrap=%b expected 20/5/0",
                     i, if8.decoder_out, if8.index_out, if8.wrap);
         end
      end
      if8.tick = 1'b0;
   endtask

   task automatic test_scan();
      logic [2:0] e_idx  [5] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1};
      logic [7:0] e_dec  [5] = '{8'h02, 8'h04, 8'h08, 8'h01, 8'h02};
      logic       e_wrap [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      if8.load = 1'b1; if8.binary_in = 3'd0;
      edge1();
      if8.load = 1'b0;
      vectors++;
      if (if8.decoder_out !== 8'h01 || if8.index_out !== 3'd0) begin
         errors++;
         $display("FAIL scan_preload dec=%h idx=%0d expected 01/0", if8.decoder_out, if8.index_out);
      end
      if8.mode = 1'b1; if8.scan_last = 3'd3; if8.tick = 1'b1;
      for (int i = 0; i < 5; i++) begin
         edge1();
         vectors++;
         if (if8.index_out !== e_idx[i] || if8.decoder_out !== e_dec[i] || if8.wrap !== e_wrap[i]) begin
            errors++;
            $display("FAIL scan_step[%0d] idx=%0d dec=%h wrap=%b expected %0d/%h/%b",
                     i, if8.index_out, if8.decoder_out, if8.wrap, e_idx[i], e_dec[i], e_wrap[i]);
         end
      end
      if8.tick = 1'b0;
      edge1();
      vectors++;
      if (if8.index_out !== 3'd1 || if8.decoder_out !== 8'h02 || if8.wrap !== 1'b0) begin
         errors++;
         $display("FAIL scan_hold idx=%0d dec=%h wrap=%b expected 1/02/0", if8.index_out, if8.decoder_out, if8.wrap);
      end
   endtask

   task automatic test_load_beats_tick();
      if8.tick = 1'b1;
      edge1();
      vectors++;
      if (if8.index_out !== 3'd2 || if8.decoder_out !== 8'h04) begin
         errors++;
         $display("FAIL lbt_setup idx=%0d dec=%h expected 2/04", if8.index_out, if8.decoder_out);
      end
      if8.load = 1'b1; if8.binary_in = 3'd6;
      edge1();
      if8.load = 1'b0;
      vectors++;
      if (if8.index_out !== 3'd6 || if8.decoder_out !== 8'h40 || if8.wrap !== 1'b0 || if_al.decoder_out !== 8'hBF) begin
         errors++;
         $display("FAIL load_beats_tick idx=%0d dec=%h wrap=%b al=%h expected 6/40/0/bf",
                  if8.index_out, if8.decoder_out, if8.wrap, if_al.decoder_out);
      end
      edge1();
      vectors++;
      if (if8.index_out !== 3'd0 || if8.decoder_out !== 8'h01 || if8.wrap !== 1'b1) begin
         errors++;
         $display("FAIL above_last_wrap idx=%0d dec=%h wrap=%b expected 0/01/1", if8.index_out, if8.decoder_out, if8.wrap);
      end
      if8.tick = 1'b0;
   endtask

   task automatic test_enable_off();
      if8.tick = 1'b1;
      edge1();
      edge1();
      vectors++;
      if (if8.index_out !== 3'd2 || if8.decoder_out !== 8'h04) begin
         errors++;
         $display("FAIL off_setup idx=%0d dec=%h expected 2/04", if8.index_out, if8.decoder_out);
      end
      if8.enable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         edge1();
         vectors++;
         if (if8.decoder_out !== 8'h00 || if8.index_out !== 3'd2 || if8.wrap !== 1'b0 || if_al.decoder_out !== 8'hFF) begin
            errors++;
            $display("FAIL off[%0d] dec=%h idx=%0d wrap=%b al=%h expected 00/2/0/ff",
                     i, if8.decoder_out, if8.index_out, if8.wrap, if_al.decoder_out);
         end
      end
      if8.enable = 1'b1; if8.tick = 1'b0;
      edge1();
      vectors++;
      if (if8.decoder_out !== 8'h04 || if8.index_out !== 3'd2) begin
         errors++;
         $display("FAIL off_resume dec=%h idx=%0d expected 04/2", if8.decoder_out, if8.index_out);
      end
      if8.tick = 1'b1;
      edge1();
      if8.tick = 1'b0;
      vectors++;
      if (if8.decoder_out !== 8'h08 || if8.index_out !== 3'd3) begin
         errors++;
         $display("FAIL off_resume_tick dec=%h idx=%0d expected 08/3", if8.decoder_out, if8.index_out);
      end
   endtask

   task automatic test_scan_last_zero();
      if8.scan_last = 3'd0; if8.tick = 1'b1;
      for (int i = 0; i < 3; i++) begin
         edge1();
         vectors++;
         if (if8.index_out !== 3'd0 || if8.decoder_out !== 8'h01 || if8.wrap !== 1'b1) begin
            errors++;
            $display("FAIL last_zero[%0d] idx=%0d dec=%h wrap=%b expected 0/01/1",
                     i, if8.index_out, if8.decoder_out, if8.wrap);
         end
      end
      if8.tick = 1'b0;
      edge1();
      vectors++;
      if (if8.wrap !== 1'b0) begin
         errors++;
         $display("FAIL last_zero_idle wrap=%b expected 0", if8.wrap);
      end
   endtask

   task automatic test_top_wrap();
      if8.scan_last = 3'd7; if8.load = 1'b1; if8.binary_in = 3'd7;
      edge1();
      if8.load = 1'b0; if8.tick = 1'b1;
      vectors++;
      if (if8.index_out !== 3'd7 || if8.decoder_out !== 8'h80 || if_al.decoder_out !== 8'h7F) begin
         errors++;
         $display("FAIL top_load idx=%0d dec=%h al=%h expected 7/80/7f", if8.index_out, if8.decoder_out, if_al.decoder_out);
      end
      edge1();
      if8.tick = 1'b0;
      vectors++;
      if (if8.index_out !== 3'd0 || if8.decoder_out !== 8'h01 || if8.wrap !== 1'b1) begin
         errors++;
         $display("FAIL top_wrap idx=%0d dec=%h wrap=%b expected 0/01/1", if8.index_out, if8.decoder_out, if8.wrap);
      end
   endtask

   task automatic test_async_reset();
      if8.tick = 1'b1;
      edge1();
      if8.tick = 1'b0;
      vectors++;
      if (if8.index_out !== 3'd1 || if8.decoder_out !== 8'h02) begin
         errors++;
         $display("FAIL async_setup idx=%0d dec=%h expected 1/02", if8.index_out, if8.decoder_out);
      end
      #3;
      rst = 1'b1;
      #1;
      vectors++;
      if (if8.decoder_out !== 8'h00 || if8.index_out !== 3'd0 || if8.wrap !== 1'b0 || if_al.decoder_out !== 8'hFF) begin
         errors++;
         $display("FAIL async_reset dec=%h idx=%0d wrap=%b al=%h expected 00/0/0/ff",
                  if8.decoder_out, if8.index_out, if8.wrap, if_al.decoder_out);
      end
      @(negedge clk);
      rst = 1'b0;
      edge1();
      vectors++;
      if (if8.decoder_out !== 8'h01 || if8.index_out !== 3'd0) begin
         errors++;
         $display("FAIL async_recover dec=%h idx=%0d expected 01/0", if8.decoder_out, if8.index_out);
      end
   endtask

   task automatic test_wide_sweep();
      logic [3:0]  e_idx;
      logic [15:0] e_dec;
      logic        e_wrap;
      if16.enable = 1'b1; if16.mode = 1'b1; if16.scan_last = 4'd15; if16.tick = 1'b0;
      edge1();
      vectors++;
      if (if16.index_out !== 4'd0 || if16.decoder_out !== 16'h0001) begin
         errors++;
         $display("FAIL wide_start idx=%0d dec=%h expected 0/0001", if16.index_out, if16.decoder_out);
      end
      if16.tick = 1'b1;
      for (int k = 0; k < 16; k++) begin
         edge1();
         e_idx  = 4'(k + 1);
         e_dec  = 16'(1) << e_idx;
         e_wrap = (k == 15);
         vectors++;
         if (if16.index_out !== e_idx || if16.decoder_out !== e_dec || if16.wrap !== e_wrap) begin
            errors++;
            $display("FAIL wide_step[%0d] idx=%0d dec=%h wrap=%b expected %0d/%h/%b",
                     k, if16.index_out, if16.decoder_out, if16.wrap, e_idx, e_dec, e_wrap);
         end
      end
      if16.tick = 1'b0;
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan();
      test_load_beats_tick();
      test_enable_off();
      test_scan_last_zero();
      test_top_wrap();
      test_async_reset();
      test_wide_sweep();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
